// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS fetch front end.
//   XLEN          width of PC and instruction words
//   NOP           value presented on inst_out when nothing is valid
//   RESET_VECTOR  first fetch address after reset
//   EXC_VECTOR    fetch address loaded on an exception
//   fetch_entry_t {pc, inst} pair carried through the prefetch queue
package mips_pkg;

    localparam int              XLEN         = 32;
    localparam logic [XLEN-1:0] NOP          = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] EXC_VECTOR   = 32'h8000_0080;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous DEPTH-entry FIFO with flush.
//   clk, rst_n   clock, async active-low reset
//   push, din    write din at the tail (ignored during flush)
//   pop, dout    dout shows the head combinationally; pop advances it
//   flush        empty the FIFO this cycle (wins over push/pop)
//   full, empty  occupancy flags
//   count        number of valid entries (0..DEPTH)
// The caller must not push when full nor pop when empty.
module if_fifo
    import mips_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  logic    flush,
    input  entry_t  din,
    output entry_t  dout,
    output logic    full,
    output logic    empty,
    output logic [AW:0] count
);

    entry_t        mem [DEPTH];
    // One extra pointer bit separates full (MSBs differ) from empty.
    logic [AW:0]   wp, rp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wp[AW-1:0]] <= din;
    end

    assign dout  = mem[rp[AW-1:0]];
    assign count = wp - rp;
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: instruction fetch stage with a prefetch queue.
//   clk, rst_n              clock, async active-low reset
//   hold_pc                 stop issuing new fetch requests
//   hold_if                 freeze pc_out/inst_out/inst_valid, no pop
//   br, pc_branch           branch redirect
//   except                  exception redirect to EXC_VECTOR (beats br)
//   imem_req/addr/gnt       request channel, transfer on req & gnt
//   imem_rvalid/rdata       in-order response channel, latency >= 1
//   pc_out/inst_out         instruction handed to decode
//   inst_valid              pc_out/inst_out valid (inst_out = NOP when 0)
// Requests in flight plus queued entries never exceed DEPTH, so a granted
// request always has a queue slot waiting for its response.
module if_prefetch
    import mips_pkg::*;
#(
    parameter int              XLEN         = mips_pkg::XLEN,
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = mips_pkg::RESET_VECTOR,
    parameter logic [XLEN-1:0] EXC_VECTOR   = mips_pkg::EXC_VECTOR,
    parameter logic [XLEN-1:0] NOP          = mips_pkg::NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold_pc,
    input  logic            hold_if,
    input  logic            br,
    input  logic [XLEN-1:0] pc_branch,
    input  logic            except,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] inst_out,
    output logic            inst_valid
);

    localparam int AW = $clog2(DEPTH);
    // Dropped-response counter; several redirects in a row can stack
    // stale responses, so it is wider than one queue's worth.
    localparam int DW = AW + 4;
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    // Same layout as fetch_entry_t, sized by this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] fetch_pc, target, a_dout;
    logic [DW-1:0]   discard;
    logic [AW:0]     q_count, a_count;
    logic [AW+1:0]   in_use;
    logic            redirect, fire, accept;
    logic            q_push, q_pop, q_full, q_empty, a_full, a_empty;
    entry_t          q_din, q_dout;
    logic            unused_ok;

    assign redirect  = except | br;
    assign target    = except ? EXC_VECTOR : {pc_branch[XLEN-1:2], 2'b00};
    // a_count is the number of live (non-discarded) requests in flight.
    assign in_use    = {1'b0, q_count} + {1'b0, a_count};
    assign imem_req  = rst_n & ~hold_pc & ~redirect & (in_use < DEPTH_W);
    assign imem_addr = fetch_pc;
    assign fire      = imem_req & imem_gnt;
    assign accept    = imem_rvalid & (discard == '0) & ~redirect;

    assign q_push    = accept;
    assign q_pop     = ~hold_if & ~q_empty & ~redirect;
    assign q_din     = '{pc: a_dout, inst: imem_rdata};
    assign unused_ok = q_full ^ a_full ^ a_empty;

    // Issued-address FIFO: the head is the PC of the next live response.
    if_fifo #(.DEPTH(DEPTH), .entry_t(logic [XLEN-1:0])) u_addr (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fire),
        .pop   (accept),
        .flush (redirect),
        .din   (fetch_pc),
        .dout  (a_dout),
        .full  (a_full),
        .empty (a_empty),
        .count (a_count)
    );

    if_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redirect),
        .din   (q_din),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_VECTOR;
            discard  <= '0;
        end else if (redirect) begin
            fetch_pc <= target;
            // Everything still in flight becomes stale; a response landing
            // this very cycle is one of them and is already gone.
            discard  <= discard + DW'(a_count) - DW'(imem_rvalid);
        end else begin
            if (fire) fetch_pc <= fetch_pc + XLEN'(4);
            if (imem_rvalid && discard != '0) discard <= discard - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out     <= '0;
            inst_out   <= NOP;
            inst_valid <= 1'b0;
        end else if (redirect || (!hold_if && q_empty)) begin
            inst_out   <= NOP;
            inst_valid <= 1'b0;
        end else if (q_pop) begin
            pc_out     <= q_dout.pc;
            inst_out   <= q_dout.inst;
            inst_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;

    localparam logic [31:0] NOP_W = 32'h0000_0000;
    localparam logic [31:0] EXC_W = 32'h8000_0080;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic        hold_pc, hold_if, br, except, imem_gnt, imem_rvalid;
    logic [31:0] pc_branch, imem_rdata;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, pc_out, inst_out;

    // DEPTH=2 instance
    logic        gnt2, rvalid2, req2, valid2;
    logic [31:0] rdata2, addr2, pc2, inst2;
    logic        tie0 = 1'b0;
    logic [31:0] tie32 = 32'h0;

    int compared = 0;
    int mismatched = 0;
    int lat = 1;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h3C00_A5A5;
    endfunction

    if_prefetch dut (
        .clk(clk), .rst_n(rst_n), .hold_pc(hold_pc), .hold_if(hold_if),
        .br(br), .pc_branch(pc_branch), .except(except),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .inst_out(inst_out), .inst_valid(inst_valid)
    );

    if_prefetch #(.DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .hold_pc(tie0), .hold_if(tie0),
        .br(tie0), .pc_branch(tie32), .except(tie0),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .pc_out(pc2), .inst_out(inst2), .inst_valid(valid2)
    );

    // In-order memory with configurable latency for the DEPTH=4 instance.
    logic [31:0] aq[$];
    int          dq[$];
    int          mcyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aq.delete();
            dq.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
        end else begin
            mcyc = mcyc + 1;
            if (imem_rvalid) begin
                aq.delete(0);
                dq.delete(0);
            end
            if (imem_req && imem_gnt) begin
                aq.push_back(imem_addr);
                dq.push_back(mcyc + lat - 1);
            end
            if (aq.size() != 0 && dq[0] <= mcyc) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= inst_of(aq[0]);
            end else begin
                imem_rvalid <= 1'b0;
                imem_rdata  <= 32'h0;
            end
        end
    end

    // Single-cycle memory for the DEPTH=2 instance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid2 <= 1'b0;
            rdata2  <= 32'h0;
        end else begin
            rvalid2 <= req2 & gnt2;
            rdata2  <= inst_of(addr2);
        end
    end

    // The credit rule must make a push into a full queue impossible.
    always @(negedge clk) begin
        if (rst_n && ((dut.q_push && dut.q_full) || (dut2.q_push && dut2.q_full))) begin
            $display("FAIL queue_overflow: push into full queue at %0t", $time);
            mismatched++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; hold_pc = 1'b0; hold_if = 1'b0; br = 1'b0; except = 1'b0;
        pc_branch = 32'h0; imem_gnt = 1'b1; gnt2 = 1'b1;
        tick(2);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hold_pc = 1'b0; hold_if = 1'b0; br = 1'b0; except = 1'b0;
        pc_branch = 32'h0; imem_gnt = 1'b1; gnt2 = 1'b1;
        tick(2);
        compared++; if (inst_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", inst_valid); mismatched++; end
        compared++; if (pc_out !== 32'h0) begin $display("FAIL reset_pc: got %h want 0", pc_out); mismatched++; end
        compared++; if (inst_out !== NOP_W) begin $display("FAIL reset_inst: got %h want %h", inst_out, NOP_W); mismatched++; end
        compared++; if (imem_req !== 1'b0) begin $display("FAIL reset_req: got %b want 0", imem_req); mismatched++; end
        compared++; if (req2 !== 1'b0 || valid2 !== 1'b0) begin $display("FAIL reset_d2: req=%b valid=%b want 0/0", req2, valid2); mismatched++; end
    endtask

    task automatic test_stream();
        lat = 1;
        do_reset();
        compared++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin $display("FAIL stream_req0: req=%b addr=%h want 1/00000000", imem_req, imem_addr); mismatched++; end
        tick();
        compared++; if (imem_addr !== 32'h4 || inst_valid !== 1'b0) begin $display("FAIL stream_c1: addr=%h valid=%b want 00000004/0", imem_addr, inst_valid); mismatched++; end
        tick();
        compared++; if (imem_addr !== 32'h8 || inst_valid !== 1'b0) begin $display("FAIL stream_c2: addr=%h valid=%b want 00000008/0", imem_addr, inst_valid); mismatched++; end
        for (int k = 0; k < 4; k++) begin
            tick();
            compared++;
            if (inst_valid !== 1'b1 || pc_out !== 32'(4*k) || inst_out !== inst_of(32'(4*k))) begin
                $display("FAIL stream_out%0d: valid=%b pc=%h inst=%h want 1/%h/%h", k, inst_valid, pc_out, inst_out, 32'(4*k), inst_of(32'(4*k)));
                mismatched++;
            end
        end
    endtask

    task automatic test_hold_if();
        lat = 1;
        do_reset();
        tick(3);
        hold_if = 1'b1;
        #1;
        compared++; if (inst_valid !== 1'b1 || pc_out !== 32'h0) begin $display("FAIL hold_first: valid=%b pc=%h want 1/00000000", inst_valid, pc_out); mismatched++; end
        tick();
        compared++; if (pc_out !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin $display("FAIL hold_c4: pc=%h req=%b addr=%h want 0/1/00000010", pc_out, imem_req, imem_addr); mismatched++; end
        for (int k = 0; k < 2; k++) begin
            tick();
            compared++;
            if (pc_out !== 32'h0 || inst_valid !== 1'b1 || imem_req !== 1'b0) begin
                $display("FAIL hold_full%0d: pc=%h valid=%b req=%b want 0/1/0", k, pc_out, inst_valid, imem_req);
                mismatched++;
            end
        end
        hold_if = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            compared++;
            if (inst_valid !== 1'b1 || pc_out !== 32'(4*k) || inst_out !== inst_of(32'(4*k))) begin
                $display("FAIL hold_resume%0d: valid=%b pc=%h want 1/%h", k, inst_valid, pc_out, 32'(4*k));
                mismatched++;
            end
        end
    endtask

    task automatic test_branch_flush();
        logic        got;
        logic [31:0] gpc, ginst;
        got = 1'b0; gpc = 32'h0; ginst = 32'h0;
        lat = 3;
        do_reset();
        tick(3);
        br = 1'b1; pc_branch = 32'h100;
        #1;
        compared++; if (imem_req !== 1'b0) begin $display("FAIL br_req_blocked: got %b want 0", imem_req); mismatched++; end
        tick();
        br = 1'b0;
        #1;
        compared++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin $display("FAIL br_target: req=%b addr=%h valid=%b want 1/00000100/0", imem_req, imem_addr, inst_valid); mismatched++; end
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (inst_valid) begin got = 1'b1; gpc = pc_out; ginst = inst_out; end
        end
        compared++; if (!got || gpc !== 32'h100 || ginst !== inst_of(32'h100)) begin $display("FAIL br_first_out: got=%b pc=%h inst=%h want 1/00000100/%h", got, gpc, ginst, inst_of(32'h100)); mismatched++; end
    endtask

    task automatic test_exc_priority();
        logic        got, saw;
        logic [31:0] gpc, ginst;
        got = 1'b0; saw = 1'b0; gpc = 32'h0; ginst = 32'h0;
        lat = 1;
        do_reset();
        tick(2);
        br = 1'b1; except = 1'b1; pc_branch = 32'h200;
        #1;
        compared++; if (imem_req !== 1'b0) begin $display("FAIL exc_req_blocked: got %b want 0", imem_req); mismatched++; end
        tick();
        br = 1'b0; except = 1'b0;
        #1;
        compared++; if (imem_req !== 1'b1 || imem_addr !== EXC_W || inst_valid !== 1'b0) begin $display("FAIL exc_target: req=%b addr=%h valid=%b want 1/%h/0", imem_req, imem_addr, inst_valid, EXC_W); mismatched++; end
        for (int k = 0; k < 12; k++) begin
            tick();
            if (imem_req && imem_addr == 32'h200) saw = 1'b1;
            if (inst_valid && !got) begin got = 1'b1; gpc = pc_out; ginst = inst_out; end
        end
        compared++; if (saw !== 1'b0) begin $display("FAIL exc_no_br_fetch: saw 0x200 request=%b want 0", saw); mismatched++; end
        compared++; if (!got || gpc !== EXC_W || ginst !== inst_of(EXC_W)) begin $display("FAIL exc_first_out: got=%b pc=%h inst=%h want 1/%h/%h", got, gpc, ginst, EXC_W, inst_of(EXC_W)); mismatched++; end
    endtask

    task automatic test_gnt_stall();
        logic [31:0] pcs[4];
        logic [31:0] insts[4];
        int          n;
        n = 0;
        do_reset();
        gnt2 = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            compared++;
            if (req2 !== 1'b1 || addr2 !== 32'h0 || valid2 !== 1'b0) begin
                $display("FAIL stall_c%0d: req=%b addr=%h valid=%b want 1/00000000/0", k, req2, addr2, valid2);
                mismatched++;
            end
            tick();
        end
        gnt2 = 1'b1;
        for (int k = 0; k < 30 && n < 4; k++) begin
            tick();
            if (valid2) begin pcs[n] = pc2; insts[n] = inst2; n++; end
        end
        compared++; if (n != 4) begin $display("FAIL stall_count: got %0d outputs want 4", n); mismatched++; end
        for (int k = 0; k < n; k++) begin
            compared++;
            if (pcs[k] !== 32'(4*k) || insts[k] !== inst_of(32'(4*k))) begin
                $display("FAIL stall_out%0d: pc=%h inst=%h want %h/%h", k, pcs[k], insts[k], 32'(4*k), inst_of(32'(4*k)));
                mismatched++;
            end
        end
    endtask

    task automatic test_reset_mid();
        lat = 1;
        do_reset();
        tick(5);
        compared++; if (inst_valid !== 1'b1 || pc_out !== 32'h8) begin $display("FAIL rmid_pre: valid=%b pc=%h want 1/00000008", inst_valid, pc_out); mismatched++; end
        rst_n = 1'b0;
        #1;
        compared++; if (inst_valid !== 1'b0 || pc_out !== 32'h0 || inst_out !== NOP_W || imem_req !== 1'b0) begin $display("FAIL rmid_clear: valid=%b pc=%h inst=%h req=%b want 0/0/%h/0", inst_valid, pc_out, inst_out, imem_req, NOP_W); mismatched++; end
        tick(2);
        rst_n = 1'b1;
        #1;
        compared++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin $display("FAIL rmid_restart: req=%b addr=%h want 1/00000000", imem_req, imem_addr); mismatched++; end
        tick(3);
        compared++; if (inst_valid !== 1'b1 || pc_out !== 32'h0 || inst_out !== inst_of(32'h0)) begin $display("FAIL rmid_first: valid=%b pc=%h inst=%h want 1/00000000/%h", inst_valid, pc_out, inst_out, inst_of(32'h0)); mismatched++; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_hold_if();
        test_branch_flush();
        test_exc_priority();
        test_gnt_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
